tick_scheduler: RTL

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_sched_pkg.sv | 17 +
 rtl/tick_channel.sv | 61 ++++++
 rtl/tick_scheduler.sv | 105 ++++++++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
// Shared defaults and FSM state encoding for the tick scheduler.
//   NCH_DEF        : number of tick channels
//   DIV_W_DEF      : divisor / channel counter width
//   SETTLE_CYC_DEF : post-reset oscillator settle time in clk cycles
package tick_sched_pkg;

  localparam int unsigned NCH_DEF        = 4;
  localparam int unsigned DIV_W_DEF      = 16;
  localparam int unsigned SETTLE_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_LOAD   = 2'd2
  } state_e;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divisor register, wrap counter and registered tick flop.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : scheduler is live (settle period over)
//   load       : write load_div this cycle and restart the period
//   load_div   : new divisor (0 disables the channel)
//   tick       : one-cycle enable pulse, high while the counter sits at div-1
//   active     : a nonzero divisor is loaded
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             tick,
  output logic             active
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = load_div;
      cnt_d = '0;
    end else if (en && (div_q != '0)) begin
      if (cnt_q == div_q - 1'b1) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // The tick flop looks at the next counter value so that it is high in
    // exactly the cycles where the counter holds div-1. A load restarts at 0,
    // which drops any tick the old period had due next cycle (except D=1).
    tick_d = en && (div_d != '0) && (cnt_d == div_d - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick   = tick_q;
  assign active = (div_q != '0);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: waits out an oscillator settle period after
// reset, then accepts per-channel divisor writes through a valid/ready port
// and emits periodic one-cycle tick pulses per channel.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   cfg_valid  : configuration request
//   cfg_ready  : scheduler can accept a configuration (RUN state)
//   cfg_ch     : target channel index
//   cfg_div    : tick period in clk cycles, 0 disables the channel
//   ready      : settle period complete, ticks are live
//   tick       : per-channel one-cycle tick pulses
//   ch_active  : per-channel nonzero divisor loaded
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned NCH        = NCH_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             ready,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   ch_active
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [1:0]       ch_sel_q, ch_sel_d;
  logic [DIV_W-1:0] div_sel_q, div_sel_d;
  logic [NCH-1:0]   load_vec;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    ch_sel_d  = ch_sel_q;
    div_sel_d = div_sel_q;
    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (cfg_valid) begin
          ch_sel_d  = cfg_ch;
          div_sel_d = cfg_div;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_SETTLE;
      settle_q  <= '0;
      ch_sel_q  <= '0;
      div_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      ch_sel_q  <= ch_sel_d;
      div_sel_q <= div_sel_d;
    end
  end

  assign ready     = (state_q != ST_SETTLE);
  assign cfg_ready = (state_q == ST_RUN);

  always_comb begin
    load_vec = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if ((state_q == ST_LOAD) && (32'(ch_sel_q) == i)) begin
        load_vec[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ready),
      .load    (load_vec[g]),
      .load_div(div_sel_q),
      .tick    (tick[g]),
      .active  (ch_active[g])
    );
  end

endmodule
